leaf_link_driver: RTL

- Network-side endpoint of one BFT leaf link: drives the 49-bit bft2interface word into a page and receives the page's interface2bft word.
- Sits between a host/DMA stream and one page instance, in place of a BFT switch leaf port.
- Provides credit-based flow control toward the page, an egress FIFO for packets the page emits, and a timeout-driven resend pulse.

---
 rtl/leaf_link_driver_pkg.sv | 14 +
 rtl/leaf_egress_fifo.sv | 43 ++++
 rtl/leaf_link_driver.sv | 133 +++++++++++++
 3 files changed

// File: rtl/leaf_link_driver_pkg.sv
// Shared packet layout and FSM encoding for the BFT leaf link driver.
package leaf_link_driver_pkg;
    localparam int WORD_W    = 49;
    localparam int PKT_W     = 48;
    localparam int VALID_BIT = 48;
    localparam int ADDR_MSB  = 47;
    localparam int ADDR_LSB  = 43;
    localparam int PORT_MSB  = 42;
    localparam int PORT_LSB  = 38;
    localparam int DATA_MSB  = 31;
    localparam int DATA_LSB  = 0;

    typedef enum logic [1:0] {IDLE, STALL, RESEND} state_e;
endpackage

// File: rtl/leaf_egress_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO succeeds only if a pop happens the same cycle.
module leaf_egress_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q;
    logic         empty, full, pop, wr_en;

    assign empty   = (wr_q == rd_q);
    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = pop_i && !empty;
    assign wr_en   = push_i && (!full || pop);
    assign drop_o  = push_i && full && !pop;
    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop)   rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/leaf_link_driver.sv
// Network-side endpoint of one BFT leaf link: credit-based send path, egress FIFO
// for page-emitted packets and a timeout-driven resend request.
module leaf_link_driver
    import leaf_link_driver_pkg::*;
#(
    parameter int         CREDITS       = 8,
    parameter int         FIFO_DEPTH    = 16,
    parameter logic [4:0] CREDIT_PORT   = 5'd31,
    parameter int         TIMEOUT       = 1024,
    parameter int         RESEND_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [PKT_W-1:0]  tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [WORD_W-1:0] din_leaf_bft2interface,
    input  logic [WORD_W-1:0] dout_leaf_interface2bft,
    output logic              resend,
    output logic [PKT_W-1:0]  rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [3:0]        credit_cnt,
    output logic              overflow,
    output logic [15:0]       drop_cnt
);
    localparam int             TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int             RW       = (RESEND_CYCLES > 1) ? $clog2(RESEND_CYCLES) : 1;
    localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0]  RS_LAST  = RW'(RESEND_CYCLES - 1);
    localparam logic [3:0]     CRED_MAX = 4'(CREDITS);

    state_e              state_q, state_d;
    logic [3:0]          credit_q, credit_d;
    logic [TW-1:0]       to_q, to_d;
    logic [RW-1:0]       rs_q, rs_d;
    logic                tx_ready_q, tx_ready_d;
    logic [WORD_W-1:0]   din_q;
    logic                overflow_q;
    logic [15:0]         drop_q;
    logic                pg_vld, credit_ret, push, send, drop;
    logic [4:0]          pg_port;

    assign pg_vld     = dout_leaf_interface2bft[VALID_BIT];
    assign pg_port    = dout_leaf_interface2bft[PORT_MSB:PORT_LSB];
    assign credit_ret = pg_vld && (pg_port == CREDIT_PORT);
    assign push       = pg_vld && (pg_port != CREDIT_PORT);
    assign send       = tx_valid && tx_ready_q;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        to_d     = to_q;
        rs_d     = rs_q;
        case (state_q)
            IDLE: begin
                if (send && !credit_ret)
                    credit_d = credit_q - 4'd1;
                else if (!send && credit_ret && credit_q != CRED_MAX)
                    credit_d = credit_q + 4'd1;
                if (credit_d == 4'd0) state_d = STALL;
            end
            STALL: begin
                if (credit_ret) begin
                    credit_d = credit_q + 4'd1;
                    to_d     = '0;
                    state_d  = IDLE;
                end else if (to_q == TO_LAST) begin
                    to_d    = '0;
                    state_d = RESEND;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            RESEND: begin
                // Returns arriving here are ignored; the full credit pool is restored on exit.
                if (rs_q == RS_LAST) begin
                    rs_d     = '0;
                    to_d     = '0;
                    credit_d = CRED_MAX;
                    state_d  = IDLE;
                end else begin
                    rs_d = rs_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        tx_ready_d = (state_d == IDLE) && (credit_d != 4'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            credit_q   <= CRED_MAX;
            to_q       <= '0;
            rs_q       <= '0;
            tx_ready_q <= 1'b0;
            din_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            to_q       <= to_d;
            rs_q       <= rs_d;
            tx_ready_q <= tx_ready_d;
            if (send) din_q <= {1'b1, tx_data};
            else      din_q[VALID_BIT] <= 1'b0;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            end
        end
    end

    leaf_egress_fifo #(.W(PKT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (push),
        .data_i  (dout_leaf_interface2bft[PKT_W-1:0]),
        .pop_i   (rx_ready),
        .data_o  (rx_data),
        .valid_o (rx_valid),
        .drop_o  (drop)
    );

    assign tx_ready               = tx_ready_q;
    assign din_leaf_bft2interface = din_q;
    assign resend                 = (state_q == RESEND);
    assign credit_cnt             = credit_q;
    assign overflow               = overflow_q;
    assign drop_cnt               = drop_q;
endmodule
